// File: rtl/core_fetch_if.sv
// core_fetch_if: instruction-bus bundle between the fetch unit and memory.
//   bus_addr  : word address of the outstanding read (driven by master)
//   bus_start : one-cycle pulse starting a read (driven by master)
//   bus_ready : read complete, bus_data valid this cycle (driven by slave)
//   bus_data  : read data (driven by slave)
// Modports: master = fetch unit, slave = memory / bus responder.
interface core_fetch_if;
  logic [29:0] bus_addr;
  logic        bus_start;
  logic        bus_ready;
  logic [31:0] bus_data;

  modport master (output bus_addr, output bus_start, input bus_ready, input bus_data);
  modport slave  (input bus_addr, input bus_start, output bus_ready, output bus_data);
endinterface

// File: rtl/core_fetch.sv
// core_fetch: instruction fetch unit. Issues word reads on the instruction bus,
// buffers returned words in a prefetch queue and presents one instruction per
// cycle to the decoder. A taken branch flushes queued and in-flight words and
// redirects fetch to branch_target.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   stall          : hold the current output instruction
//   branch         : flush and redirect (highest priority)
//   branch_target  : word address of the redirect target
//   bus            : core_fetch_if.master (bus_addr/bus_start out, bus_ready/bus_data in)
//   insn, insn_pc  : instruction and its word address
//   insn_valid     : insn is real (0 = bubble)
//
// Configuration macro: CORE_FETCH_QUEUE_EN
//   defined   -> prefetch queue of QUEUE_DEPTH entries (power of two >= 2)
//   undefined -> single-entry queue; a new read issues only once the previous
//                word has been popped
module core_fetch #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch,
  input  logic [29:0]  branch_target,
  core_fetch_if.master bus,
  output logic [31:0]  insn,
  output logic [29:0]  insn_pc,
  output logic         insn_valid
);

`ifdef CORE_FETCH_QUEUE_EN
  localparam int DEPTH = QUEUE_DEPTH;
`else
  // Single entry regardless of QUEUE_DEPTH.
  localparam int DEPTH = (QUEUE_DEPTH > 0) ? 1 : 1;
`endif
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QSIZE = 1 << AW;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e              state_q, state_d;
  logic [29:0]         fetch_pc_q, fetch_pc_d;
  logic [29:0]         bus_addr_q, bus_addr_d;
  logic                bus_start_q, bus_start_d;
  entry_t [QSIZE-1:0]  mem_q, mem_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [31:0]         insn_q, insn_d;
  logic [29:0]         insn_pc_q, insn_pc_d;
  logic                insn_valid_q, insn_valid_d;

  logic push, pop, room, issue;

  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_start = bus_start_q;
  assign insn          = insn_q;
  assign insn_pc       = insn_pc_q;
  assign insn_valid    = insn_valid_q;

  // Queue and output stage. Branch wins over push, pop and stall.
  always_comb begin
    push         = (state_q == S_WAIT) && bus.bus_ready && !branch;
    pop          = !branch && !stall && (count_q != '0);
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    insn_d       = insn_q;
    insn_pc_d    = insn_pc_q;
    insn_valid_d = insn_valid_q;

    if (branch) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      insn_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: fetch_pc_q, word: bus.bus_data};
        wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
        insn_d    = mem_q[rd_ptr_q].word;
        insn_pc_d = mem_q[rd_ptr_q].pc;
        rd_ptr_d  = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (!stall) insn_valid_d = pop;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Bus FSM. Room is judged on next-edge queue occupancy; the outstanding
  // request (if any) completes on the same edge we would issue from, so it no
  // longer counts. Completing a read and issuing the next one are folded into
  // a single edge (ready -> IDLE -> issue), which gives back-to-back reads of
  // issue, ready, issue and a restart one cycle after a discarded read returns.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    bus_addr_d  = bus_addr_q;
    bus_start_d = 1'b0;
    issue       = 1'b0;
    room        = (count_d < CW'(DEPTH));

    case (state_q)
      S_IDLE: begin
        // A stray bus_ready here (e.g. after reset) is ignored.
        if (branch) fetch_pc_d = branch_target;
        else        issue      = room;
      end
      S_WAIT: begin
        if (branch) begin
          fetch_pc_d = branch_target;
          // A ready on the branch edge retires the read, so nothing is left to discard.
          state_d    = bus.bus_ready ? S_IDLE : S_DISCARD;
        end else if (bus.bus_ready) begin
          fetch_pc_d = fetch_pc_q + 30'd1;
          state_d    = S_IDLE;
          issue      = room;
        end
      end
      S_DISCARD: begin
        if (branch) begin
          fetch_pc_d = branch_target;
          if (bus.bus_ready) state_d = S_IDLE;
        end else if (bus.bus_ready) begin
          state_d = S_IDLE;
          issue   = room;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      bus_start_d = 1'b1;
      bus_addr_d  = fetch_pc_d;
      state_d     = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= '0;
      bus_addr_q   <= '0;
      bus_start_q  <= 1'b0;
      mem_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      insn_q       <= '0;
      insn_pc_q    <= '0;
      insn_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      bus_addr_q   <= bus_addr_d;
      bus_start_q  <= bus_start_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      insn_q       <= insn_d;
      insn_pc_q    <= insn_pc_d;
      insn_valid_q <= insn_valid_d;
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
module tb_core_fetch;
`ifdef CORE_FETCH_QUEUE_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [29:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [29:0] target;
    logic [29:0] pc0;
    logic [29:0] pc1;
    logic [31:0] insn0;
    logic [31:0] insn1;
  } bvec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [29:0] branch_target = '0;
  logic [31:0] insn;
  logic [29:0] insn_pc;
  logic        insn_valid;

  core_fetch_if bus ();

  core_fetch #(.QUEUE_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch       (branch),
    .branch_target(branch_target),
    .bus          (bus),
    .insn         (insn),
    .insn_pc      (insn_pc),
    .insn_valid   (insn_valid)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [29:0] exp_issue = '0;
  bit          mem_pend = 1'b0;
  bit          mem_disc = 1'b0;
  int          mem_cnt  = 0;
  logic [29:0] mem_addr = '0;
  int          lat = 1;
  int          starts = 0, pops = 0, dead_seen = 0, disc_resp = 0;
  int          cap_n = 0;
  logic [29:0] cap_pc[2];
  logic [31:0] cap_insn[2];

  function automatic logic [31:0] mdata(input logic [29:0] a);
    return 32'hE000_0000 + {2'b00, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs #1 after the edge, update the scoreboard and
  // drive the memory responder for the next cycle.
  task automatic step();
    logic        st, br, rs;
    logic [29:0] tg;
    logic [31:0] p_insn;
    logic [29:0] p_pc;
    logic        p_valid;
    exp_t        e;
    st = stall; br = branch; rs = rst; tg = branch_target;
    p_insn = insn; p_pc = insn_pc; p_valid = insn_valid;
    @(posedge clk);
    #1;
    if (bus.bus_ready) mem_pend = 1'b0;
    bus.bus_ready = 1'b0;

    if (rs) begin
      sb.delete();
      exp_issue = '0; mem_pend = 1'b0; mem_disc = 1'b0; cap_n = 0;
      chk("rst_bus_start", bus.bus_start, 0);
      chk("rst_bus_addr", bus.bus_addr, 0);
      chk("rst_insn", insn, 0);
      chk("rst_insn_pc", insn_pc, 0);
      chk("rst_insn_valid", insn_valid, 0);
      return;
    end

    if (br) begin
      chk("branch_valid", insn_valid, 0);
      sb.delete();
      exp_issue = tg;
      cap_n = 0;
      if (mem_pend) mem_disc = 1'b1;
    end else if (st) begin
      chk("stall_hold", {insn_valid, insn_pc, insn}, {p_valid, p_pc, p_insn});
    end else if (insn_valid) begin
      pops++;
      if (insn == 32'h0000_DEAD) dead_seen++;
      if (cap_n < 2) begin
        cap_pc[cap_n] = insn_pc; cap_insn[cap_n] = insn; cap_n++;
      end
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_pop: got pc=%0h insn=%0h expected no instruction", insn_pc, insn);
      end else begin
        e = sb.pop_front();
        chk("insn_pc", insn_pc, e.pc);
        chk("insn", insn, e.word);
      end
    end

    // Respond to a request issued on an earlier edge.
    if (mem_pend) begin
      if (mem_cnt > 1) mem_cnt--;
      else begin
        bus.bus_ready = 1'b1;
        if (mem_disc) begin
          bus.bus_data = 32'h0000_DEAD;
          disc_resp++;
        end else begin
          bus.bus_data = mdata(mem_addr);
          e.pc = exp_issue; e.word = mdata(exp_issue);
          sb.push_back(e);
          exp_issue = exp_issue + 30'd1;
        end
      end
    end

    if (bus.bus_start) begin
      starts++;
      chk("bus_addr", bus.bus_addr, exp_issue);
      chk("issue_overlap", mem_pend, 0);
      mem_pend = 1'b1; mem_disc = 1'b0; mem_cnt = lat; mem_addr = bus.bus_addr;
    end
  endtask

  task automatic wait_start(input string tag);
    int i;
    i = 0;
    do begin step(); i++; end while (!bus.bus_start && i < 40);
    chk(tag, bus.bus_start, 1);
  endtask

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    do begin step(); i++; end while (!(bus.bus_ready && !mem_disc) && i < 40);
    chk(tag, bus.bus_ready, 1);
  endtask

  initial begin
    bvec_t bv[4];
    int    s0;
    bv[0] = '{30'h0000_0100, 30'h0000_0100, 30'h0000_0101, 32'hE000_0100, 32'hE000_0101};
    bv[1] = '{30'h3FFF_FFFF, 30'h3FFF_FFFF, 30'h0000_0000, 32'h1FFF_FFFF, 32'hE000_0000};
    bv[2] = '{30'h3FFF_FFFE, 30'h3FFF_FFFE, 30'h3FFF_FFFF, 32'h1FFF_FFFE, 32'h1FFF_FFFF};
    bv[3] = '{30'h000A_BCDE, 30'h000A_BCDE, 30'h000A_BCDF, 32'hE00A_BCDE, 32'hE00A_BCDF};

    bus.bus_ready = 1'b0;
    bus.bus_data  = '0;

    // Reset and plain streaming.
    rst = 1'b1; step(); step(); rst = 1'b0;
    repeat (24) step();
    chk("stream_progress", pops >= 5, 1);
    chk("stream_first_pc", cap_pc[0], 30'h0);
    chk("stream_first_insn", cap_insn[0], 32'hE000_0000);
    chk("stream_second_pc", cap_pc[1], 30'h1);

    // Back-pressure: queue fills to depth, then issue stops.
    stall = 1'b1;
    repeat (10) step();
    chk("stall_fill", sb.size(), DEPTH);
    chk("stall_no_request", mem_pend, 0);
    s0 = starts;
    step();
    chk("stall_no_start", starts, s0);
    stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      chk("release_pop", insn_valid, 1);
    end
    repeat (6) step();

    // Branch while a slow read is outstanding: the read returns 0xDEAD and must be dropped.
    lat = 3;
    wait_start("wait_start_slow");
    branch = 1'b1; branch_target = 30'h100;
    step();
    branch = 1'b0; lat = 1;
    repeat (15) step();
    chk("discard_seen", disc_resp >= 1, 1);
    chk("dead_never", dead_seen, 0);
    chk("br_first_pc", cap_pc[0], 30'h100);
    chk("br_first_insn", cap_insn[0], 32'hE000_0100);

    // Branch on the same edge as bus_ready: word dropped, immediate reissue.
    wait_ready("wait_ready_same");
    branch = 1'b1; branch_target = 30'h200; s0 = starts;
    step();
    branch = 1'b0;
    chk("same_no_issue", starts, s0);
    step();
    chk("same_reissue", bus.bus_start, 1);
    repeat (10) step();
    chk("same_first_pc", cap_pc[0], 30'h200);

    // Table of redirect targets, including the 30-bit wrap.
    for (int v = 0; v < 4; v++) begin
      branch = 1'b1; branch_target = bv[v].target;
      step();
      branch = 1'b0;
      for (int i = 0; i < 40 && cap_n < 2; i++) step();
      chk("bvec_count", cap_n, 2);
      chk("bvec_pc0", cap_pc[0], bv[v].pc0);
      chk("bvec_pc1", cap_pc[1], bv[v].pc1);
      chk("bvec_insn0", cap_insn[0], bv[v].insn0);
      chk("bvec_insn1", cap_insn[1], bv[v].insn1);
    end

    // Reset during WAIT, then a stray bus_ready that must be ignored.
    lat = 3;
    wait_start("wait_start_rst");
    rst = 1'b1;
    step();
    rst = 1'b0; lat = 1;
    bus.bus_ready = 1'b1; bus.bus_data = 32'hBAD0_BAD0;
    step();
    chk("rst_first_issue", bus.bus_start, 1);
    repeat (12) step();
    chk("rst_first_pc", cap_pc[0], 30'h0);
    chk("rst_first_insn", cap_insn[0], 32'hE000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
